t5_muldiv: RTL
==============

Name: t5_muldiv

Overview:
- Iterative multiply/divide unit for the RV M extension, parametrised in XLEN (32 or 64) and in hart-tag width.
- Sits beside the execute-stage ALU. Decode launches an operation with a one-cycle strobe; the block runs multi-cycle and returns a tagged result with a one-cycle ready pulse.
- Supports pipeline stall (sena) and flush (dkil), which the single-cycle ALU never needed.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- TAGW, 2, width of hart/writeback tag carried with each operation.

Ports:
- sclk  input  1  clock
- srst  input  1  reset, synchronous, active-high
- sena  input  1  pipeline enable; 0 freezes all state
- dkil  input  1  flush; aborts any operation in flight
- dstb  input  1  start strobe
- dfn3  input  3  RV funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- dop1  input  XLEN  rs1 operand
- dop2  input  XLEN  rs2 operand
- dtag  input  TAGW  tag returned with result
- xbsy  output  1  unit occupied; decode must not strobe
- xrdy  output  1  result valid, one-cycle pulse
- xres  output  XLEN  result
- xtag  output  TAGW  tag of xres

Behaviour:
- Clock sclk; reset srst, synchronous, active-high.
- Reset values: state IDLE, xbsy 0, xrdy 0, xres 0, xtag 0, all internal registers 0.
- sena=0: every register holds, including the state and the cycle counter. dkil and dstb are ignored while sena=0.
- The FSM advances only when sena=1. States:
  - IDLE
  - CALC
  - SIGN
  - DONE
- Accept: dstb=1 and state is IDLE or DONE (back-to-back allowed). dfn3, dop1, dop2 and dtag are captured on the accepting edge.
- dstb while in CALC or SIGN is ignored; no error is raised.
- xbsy = state is CALC or SIGN. xrdy = state is DONE.
- Operand preparation on accept:
  - Signed operands (MULH, DIV, REM; op1 only for MULHSU) are converted to magnitude.
  - Result-sign flags are recorded: product sign = s1 xor s2; quotient sign = s1 xor s2; remainder sign = s1.
- Special cases on accept go straight to DONE, skipping CALC and SIGN:
  - Divide by zero (op2 == 0): quotient = all ones; remainder = dop1 unchanged.
  - Signed overflow (DIV/REM, dop1 = 1 followed by XLEN-1 zeros, dop2 = all ones): quotient = dop1; remainder = 0.
  - Latency for both: xrdy in the cycle after accept.
- CALC runs exactly XLEN cycles, one bit per cycle, using a counter that counts down from XLEN-1 to 0.
  - Multiply: shift-add on a 2*XLEN accumulator.
  - Divide: restoring division, 1-bit quotient per cycle, with an XLEN+1-bit partial remainder.
  - Counter reaching 0 → SIGN.
- SIGN (1 cycle): conditionally two's-complement negate the 2*XLEN product, quotient or remainder. Then select:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Register into xres, then → DONE.
- Normal latency: xrdy asserted XLEN+2 enabled cycles after the accepting edge (34 for XLEN=32).
- DONE lasts one enabled cycle. It goes → IDLE, or → CALC/DONE if a new dstb is accepted in that cycle.
- xres and xtag hold their last values after DONE until the next result.
- dkil with sena=1: state → IDLE, xrdy not asserted for the killed operation, xres/xtag unchanged.
  - dkil has priority over dstb in the same cycle: the new operation is not accepted.
- Reset mid-operation: returns to the reset values immediately; no xrdy.
- All arithmetic is modulo 2^XLEN per the RV spec. No exceptions are raised.

Test Plan:
- Reset, then MUL 7 × 0xFFFFFFFD (−3), XLEN=32, dtag=2 → xbsy high 33 cycles; xrdy pulse at cycle 34; xres=0xFFFFFFEB, xtag=2.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with xrdy 1 cycle after strobe; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0, also 1-cycle latency.
- Stall and flush:
  - sena low for 10 cycles mid-CALC → xrdy slips by exactly 10 cycles with the result unchanged.
  - dkil at cycle 5 of CALC → no xrdy, xbsy drops the next cycle, xres keeps its previous value.
  - dkil together with dstb → operation not accepted.
- Back-to-back: new dstb in the DONE cycle → accepted; second xrdy exactly 34 cycles later. XLEN=64 build: MULHU all-ones × all-ones → 0xFFFFFFFFFFFFFFFE with latency 66.

Source files
------------

// File: rtl/t5_muldiv.sv
// t5_muldiv: iterative RV M-extension multiply/divide unit.
// Multiply is a shift-add on a 2*XLEN accumulator. Divide is a restoring
// division that yields one quotient bit per cycle. Both operate on operand
// magnitudes, and a final SIGN cycle applies the recorded result signs.
module t5_muldiv #(
  parameter int XLEN = 32,
  parameter int TAGW = 2
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic            dkil,
  input  logic            dstb,
  input  logic [2:0]      dfn3,
  input  logic [XLEN-1:0] dop1,
  input  logic [XLEN-1:0] dop2,
  input  logic [TAGW-1:0] dtag,
  output logic            xbsy,
  output logic            xrdy,
  output logic [XLEN-1:0] xres,
  output logic [TAGW-1:0] xtag
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          fn_q, fn_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     dvs_q, dvs_d;
  logic                negp_q, negp_d;
  logic                negr_q, negr_d;
  logic [TAGW-1:0]     tag_q, tag_d;
  logic [XLEN-1:0]     xres_q, xres_d;
  logic [TAGW-1:0]     xtag_q, xtag_d;
  logic                xbsy_q, xbsy_d;
  logic                xrdy_q, xrdy_d;

  // Operand signedness, magnitudes and special-case detection at accept time.
  logic            sgn1, sgn2, s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf;

  assign sgn1 = (dfn3 == 3'd1) || (dfn3 == 3'd2) || (dfn3 == 3'd4) || (dfn3 == 3'd6);
  assign sgn2 = (dfn3 == 3'd1) || (dfn3 == 3'd4) || (dfn3 == 3'd6);
  assign s1   = sgn1 & dop1[XLEN-1];
  assign s2   = sgn2 & dop2[XLEN-1];
  assign mag1 = s1 ? (~dop1 + 1'b1) : dop1;
  assign mag2 = s2 ? (~dop2 + 1'b1) : dop2;
  assign div_zero = dfn3[2] && (dop2 == '0);
  assign div_ovf  = dfn3[2] && !dfn3[0] && (dop1 == {1'b1, {(XLEN-1){1'b0}}})
                    && (dop2 == {XLEN{1'b1}});

  // One shift-add multiply step: add the multiplicand when the multiplier LSB
  // is set, then shift the whole accumulator right, keeping the carry.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring divide step: the upper half is the partial remainder, the
  // lower half shifts the dividend out and the quotient bits in.
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_step;

  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, dvs_q};
  assign div_step  = div_diff[XLEN]
                   ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                   : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  // Sign fix-up and result selection used in the SIGN cycle.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, sign_res;

  assign prod_fix = negp_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = negp_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem_fix  = negr_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

  // Pick the low product, high product, quotient or remainder by funct3.
  always_comb begin
    sign_res = prod_fix[XLEN-1:0];
    case (fn_q)
      3'd0:             sign_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: sign_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       sign_res = quo_fix;
      default:          sign_res = rem_fix;
    endcase
  end

  // Next-state logic; nothing moves unless the pipeline is enabled, and a
  // flush beats a simultaneous start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fn_d    = fn_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    tag_d   = tag_q;
    xres_d  = xres_q;
    xtag_d  = xtag_q;
    if (sena) begin
      if (dkil) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            state_d = IDLE;
            if (dstb) begin
              fn_d   = dfn3;
              tag_d  = dtag;
              negp_d = s1 ^ s2;
              negr_d = s1;
              cnt_d  = CW'(XLEN-1);
              if (dfn3[2]) begin
                acc_d = {{XLEN{1'b0}}, mag1};
                dvs_d = mag2;
              end else begin
                acc_d = {{XLEN{1'b0}}, mag2};
                dvs_d = mag1;
              end
              if (div_zero) begin
                state_d = DONE;
                xres_d  = dfn3[1] ? dop1 : {XLEN{1'b1}};
                xtag_d  = dtag;
              end else if (div_ovf) begin
                state_d = DONE;
                xres_d  = dfn3[1] ? {XLEN{1'b0}} : dop1;
                xtag_d  = dtag;
              end else begin
                state_d = CALC;
              end
            end
          end
          CALC: begin
            acc_d = fn_q[2] ? div_step : mul_step;
            if (cnt_q == '0) state_d = SIGN;
            else cnt_d = cnt_q - 1'b1;
          end
          SIGN: begin
            xres_d  = sign_res;
            xtag_d  = tag_q;
            state_d = DONE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
    xbsy_d = (state_d == CALC) || (state_d == SIGN);
    xrdy_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sclk) begin
    if (srst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fn_q    <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      tag_q   <= '0;
      xres_q  <= '0;
      xtag_q  <= '0;
      xbsy_q  <= 1'b0;
      xrdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fn_q    <= fn_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      tag_q   <= tag_d;
      xres_q  <= xres_d;
      xtag_q  <= xtag_d;
      xbsy_q  <= xbsy_d;
      xrdy_q  <= xrdy_d;
    end
  end

  assign xbsy = xbsy_q;
  assign xrdy = xrdy_q;
  assign xres = xres_q;
  assign xtag = xtag_q;

endmodule
